jt12_regwr: RTL and testbench

CPU write front-end for the FM register file. It latches the YM2612-style bus address and data and decodes each data write into a channel/operator selector plus one `up_*` strobe. It holds that strobe for one full 24-slot operator cycle, so the downstream register stage's slot counter is guaranteed to pass the matching slot. It also owns the global registers (0x27 mode, 0x28 key-on), the FNUM high-byte latches and the CH3 special-mode FNUM/BLOCK storage.

---
 rtl/jt12_regwr.sv | 180 ++++++++++++++++++
 tb/tb_jt12_regwr.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_regwr.sv
// jt12_regwr: YM2612 bus write front-end; decodes data writes into a strobe held for SLOTS clk_en ticks.
// Define JT12_REGWR_QUEUE_EN to buffer one data write that arrives while a strobe window is open.
module jt12_regwr #(
    parameter int SLOTS = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        cs_n,
    input  logic        wr_n,
    input  logic [1:0]  addr,
    input  logic [7:0]  din,
    output logic        busy,
    output logic [2:0]  ch,
    output logic [1:0]  op,
    output logic [7:0]  dout,
    output logic        up_keyon,
    output logic        up_alg,
    output logic        up_fnumlo,
    output logic        up_pms,
    output logic        up_dt1,
    output logic        up_tl,
    output logic        up_ks_ar,
    output logic        up_amen_dr,
    output logic        up_sr,
    output logic        up_sl_rr,
    output logic        up_ssgeg,
    output logic [5:0]  latch_fnum,
    output logic        effect,
    output logic        csm,
    output logic [10:0] fnum_ch3op1,
    output logic [10:0] fnum_ch3op2,
    output logic [10:0] fnum_ch3op3,
    output logic [2:0]  block_ch3op1,
    output logic [2:0]  block_ch3op2,
    output logic [2:0]  block_ch3op3
);
    logic        r_req, r_req_d, r_part;
    logic [1:0]  r_addr;
    logic [7:0]  r_din, r_reg;
    logic [4:0]  r_cnt;
    logic [5:0]  r_latch_ch3;
    logic [10:0] r_up;
    logic        w_event, w_addr_wr, w_data_wr, w_end, w_start, w_s_part, w_chok, w_glob;
    logic [7:0]  w_s_reg, w_s_din;
    logic [10:0] w_up;

    assign w_event   = r_req & ~r_req_d;
    assign w_addr_wr = w_event & ~r_addr[0];
    assign w_data_wr = w_event & r_addr[0];
    assign w_end     = busy & clk_en & (r_cnt == 5'(SLOTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req   <= 1'b0;
            r_req_d <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            r_req   <= ~cs_n & ~wr_n;
            r_req_d <= r_req;
            r_addr  <= addr;
            r_din   <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg  <= '0;
            r_part <= 1'b0;
        end else if (w_addr_wr) begin
            r_reg  <= r_din;
            r_part <= r_addr[1];
        end
    end

`ifdef JT12_REGWR_QUEUE_EN
    logic       r_pend, r_pend_part, w_issue;
    logic [7:0] r_pend_reg, r_pend_din;

    assign w_issue  = w_end & r_pend;
    assign w_start  = w_issue | (w_data_wr & ~r_pend & (~busy | w_end));
    assign w_s_reg  = w_issue ? r_pend_reg  : r_reg;
    assign w_s_part = w_issue ? r_pend_part : r_part;
    assign w_s_din  = w_issue ? r_pend_din  : r_din;

    // The entry snapshots reg/part so later address writes cannot retarget it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_part <= 1'b0;
            r_pend_reg  <= '0;
            r_pend_din  <= '0;
        end else if (w_issue) begin
            r_pend <= 1'b0;
        end else if (w_data_wr && busy && !w_end && !r_pend) begin
            r_pend      <= 1'b1;
            r_pend_part <= r_part;
            r_pend_reg  <= r_reg;
            r_pend_din  <= r_din;
        end
    end
`else
    assign w_start  = w_data_wr & (~busy | w_end);
    assign w_s_reg  = r_reg;
    assign w_s_part = r_part;
    assign w_s_din  = r_din;
`endif

    assign w_chok = w_s_reg[1:0] != 2'd3;
    assign w_glob = ~w_s_part;
    assign w_up = {
        w_glob && w_s_reg == 8'h28,
        w_chok && w_s_reg[7:2] == 6'h2C,
        w_chok && w_s_reg[7:2] == 6'h28,
        w_chok && w_s_reg[7:2] == 6'h2D,
        w_chok && w_s_reg[7:4] == 4'h3,
        w_chok && w_s_reg[7:4] == 4'h4,
        w_chok && w_s_reg[7:4] == 4'h5,
        w_chok && w_s_reg[7:4] == 4'h6,
        w_chok && w_s_reg[7:4] == 4'h7,
        w_chok && w_s_reg[7:4] == 4'h8,
        w_chok && w_s_reg[7:4] == 4'h9
    };
    assign {up_keyon, up_alg, up_fnumlo, up_pms, up_dt1, up_tl,
            up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg} = r_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            r_cnt <= '0;
            r_up  <= '0;
            ch    <= '0;
            op    <= '0;
            dout  <= '0;
        end else if (w_start) begin
            busy  <= 1'b1;
            r_cnt <= '0;
            r_up  <= w_up;
            ch    <= {w_s_part, w_s_reg[1:0]};
            op    <= w_s_reg[3:2];
            dout  <= w_s_din;
        end else if (w_end) begin
            busy <= 1'b0;
            r_up <= '0;
        end else if (busy && clk_en) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_fnum   <= '0;
            r_latch_ch3  <= '0;
            effect       <= 1'b0;
            csm          <= 1'b0;
            fnum_ch3op1  <= '0;
            fnum_ch3op2  <= '0;
            fnum_ch3op3  <= '0;
            block_ch3op1 <= '0;
            block_ch3op2 <= '0;
            block_ch3op3 <= '0;
        end else if (w_start) begin
            if (w_chok && w_s_reg[7:2] == 6'h29)
                latch_fnum <= w_s_din[5:0];
            if (w_chok && w_s_reg[7:2] == 6'h2B)
                r_latch_ch3 <= w_s_din[5:0];
            if (w_glob && w_s_reg == 8'hA8)
                {block_ch3op3, fnum_ch3op3} <= {r_latch_ch3, w_s_din};
            if (w_glob && w_s_reg == 8'hA9)
                {block_ch3op1, fnum_ch3op1} <= {r_latch_ch3, w_s_din};
            if (w_glob && w_s_reg == 8'hAA)
                {block_ch3op2, fnum_ch3op2} <= {r_latch_ch3, w_s_din};
            if (w_glob && w_s_reg == 8'h27) begin
                effect <= |w_s_din[7:6];
                csm    <= w_s_din[7:6] == 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_jt12_regwr.sv
// tb_jt12_regwr: directed + randomised bus writes checked every cycle against a behavioural model.
module tb_jt12_regwr;
    localparam int SLOTS = 24;
`ifdef JT12_REGWR_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, cs_n = 1'b1, wr_n = 1'b1;
    logic [1:0] addr = '0;
    logic [7:0] din = '0;
    logic busy, effect, csm;
    logic [2:0] ch, block_ch3op1, block_ch3op2, block_ch3op3;
    logic [1:0] op;
    logic [7:0] dout;
    logic up_keyon, up_alg, up_fnumlo, up_pms, up_dt1, up_tl, up_ks_ar, up_amen_dr, up_sr, up_sl_rr, up_ssgeg;
    logic [5:0] latch_fnum;
    logic [10:0] fnum_ch3op1, fnum_ch3op2, fnum_ch3op3;

    jt12_regwr #(.SLOTS(SLOTS)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
        .busy(busy), .ch(ch), .op(op), .dout(dout),
        .up_keyon(up_keyon), .up_alg(up_alg), .up_fnumlo(up_fnumlo), .up_pms(up_pms), .up_dt1(up_dt1),
        .up_tl(up_tl), .up_ks_ar(up_ks_ar), .up_amen_dr(up_amen_dr), .up_sr(up_sr), .up_sl_rr(up_sl_rr),
        .up_ssgeg(up_ssgeg), .latch_fnum(latch_fnum), .effect(effect), .csm(csm),
        .fnum_ch3op1(fnum_ch3op1), .fnum_ch3op2(fnum_ch3op2), .fnum_ch3op3(fnum_ch3op3),
        .block_ch3op1(block_ch3op1), .block_ch3op2(block_ch3op2), .block_ch3op3(block_ch3op3)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0, busy_cycles = 0;
    bit en_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model state: strobe order keyon,alg,fnumlo,pms,dt1,tl,ks_ar,amen_dr,sr,sl_rr,ssgeg
    typedef struct packed { logic [7:0] r; logic p; logic [7:0] d; } wr_t;
    wr_t m_q[$];
    logic [10:0] m_up;
    logic [2:0] m_ch, m_b[3];
    logic [1:0] m_op, m_ev_addr;
    logic [7:0] m_dout, m_reg, m_ev_din;
    logic [5:0] m_lfnum, m_lch3;
    logic m_effect, m_csm, m_part;
    logic [10:0] m_f[3];
    int m_left;
    bit m_prev, m_armed;

    function automatic logic [10:0] decode(input logic [7:0] r, input logic p);
        int rn = int'(r);
        logic [10:0] v = '0;
        if (!p && rn == 'h28) v[10] = 1'b1;
        if (rn % 4 != 3) begin
            if (rn >= 'h30 && rn <= 'h9F) v[6 - (rn / 16 - 3)] = 1'b1;
            if (rn >= 'hA0 && rn <= 'hA2) v[8] = 1'b1;
            if (rn >= 'hB0 && rn <= 'hB2) v[9] = 1'b1;
            if (rn >= 'hB4 && rn <= 'hB6) v[7] = 1'b1;
        end
        return v;
    endfunction

    task automatic m_start(input logic [7:0] r, input logic p, input logic [7:0] d);
        int rn = int'(r);
        m_up = decode(r, p);
        m_left = SLOTS;
        m_ch = 3'(int'(p) * 4 + rn % 4);
        m_op = 2'((rn / 4) % 4);
        m_dout = d;
        if (rn >= 'hA4 && rn <= 'hA6) m_lfnum = d[5:0];
        if (rn >= 'hAC && rn <= 'hAE) m_lch3 = d[5:0];
        if (!p) begin
            if (rn == 'hA9) {m_b[0], m_f[0]} = {m_lch3, d};
            if (rn == 'hAA) {m_b[1], m_f[1]} = {m_lch3, d};
            if (rn == 'hA8) {m_b[2], m_f[2]} = {m_lch3, d};
            if (rn == 'h27) begin
                m_effect = d >= 8'h40;
                m_csm = d >= 8'h80 && d < 8'hC0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_up = '0; m_ch = '0; m_op = '0; m_dout = '0; m_reg = '0; m_part = 1'b0;
            m_lfnum = '0; m_lch3 = '0; m_effect = 1'b0; m_csm = 1'b0; m_left = 0;
            for (int i = 0; i < 3; i++) begin m_f[i] = '0; m_b[i] = '0; end
            m_prev = 1'b0; m_armed = 1'b0; m_ev_addr = '0; m_ev_din = '0;
        end else begin
            bit ended, full;
            wr_t e;
            ended = m_left == 1 && clk_en;
            if (m_left > 0 && clk_en) m_left--;
            full = m_q.size() > 0;
            if (ended) begin
                m_up = '0;
                if (full) begin e = m_q.pop_front(); m_start(e.r, e.p, e.d); end
            end
            if (m_armed) begin
                if (!m_ev_addr[0]) begin m_reg = m_ev_din; m_part = m_ev_addr[1]; end
                else if (m_left == 0) m_start(m_reg, m_part, m_ev_din);
                else if (QUEUE && !full) m_q.push_back('{m_reg, m_part, m_ev_din});
            end
            m_armed = !cs_n && !wr_n && !m_prev;
            m_prev = !cs_n && !wr_n;
            m_ev_addr = addr;
            m_ev_din = din;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("strobes", {busy, up_keyon, up_alg, up_fnumlo, up_pms, up_dt1, up_tl, up_ks_ar,
                  up_amen_dr, up_sr, up_sl_rr, up_ssgeg}, {m_left > 0, m_up});
            check("fields", {ch, op, dout}, {m_ch, m_op, m_dout});
            check("globals", {latch_fnum, effect, csm}, {m_lfnum, m_effect, m_csm});
            check("ch3", {block_ch3op1, fnum_ch3op1, block_ch3op2, fnum_ch3op2, block_ch3op3, fnum_ch3op3},
                  {m_b[0], m_f[0], m_b[1], m_f[1], m_b[2], m_f[2]});
            if (busy) busy_cycles++;
        end
    end

    initial forever begin
        @(negedge clk);
        clk_en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        @(negedge clk);
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || m_left > 0 || m_q.size() > 0 || m_armed) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle", busy, 1'b0);
    endtask

    logic [7:0] tbl[16] = '{8'h27, 8'h28, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hAC, 8'hAD,
                            8'hA8, 8'hA9, 8'hAA, 8'hA0, 8'hA3, 8'hB0, 8'hB5, 8'hB7};

    initial begin
        int k;
        logic p;
        logic [7:0] rv;
        repeat (3) @(negedge clk);
        check("rst_busy", {busy, dout, ch, op}, '0);
        rst_n = 1'b1;
        // TL write: 0x4A part 0 -> ch 2, op 2, held 24 ticks
        bus_wr(2'b00, 8'h4A);
        bus_wr(2'b01, 8'h15);
        check("tl_strobe", {up_tl, ch, op, dout}, {1'b1, 3'd2, 2'd2, 8'h15});
        k = 1;
        while (busy && k < 100) begin
            @(negedge clk);
            if (busy) k++;
        end
        check("tl_len", k, 24);
        check("tl_clear", up_tl, 1'b0);
        // Part-1 FNUM high latch then low byte
        bus_wr(2'b10, 8'hA5);
        bus_wr(2'b11, 8'h2C);
        wait_idle();
        bus_wr(2'b10, 8'hA1);
        bus_wr(2'b11, 8'h80);
        check("p1_fnum", {latch_fnum, up_fnumlo, ch}, {6'h2C, 1'b1, 3'd5});
        wait_idle();
        // CH3 special mode
        bus_wr(2'b00, 8'hAC);
        bus_wr(2'b01, 8'h1B);
        wait_idle();
        bus_wr(2'b00, 8'hA9);
        bus_wr(2'b01, 8'h44);
        check("ch3_op1", {block_ch3op1, fnum_ch3op1}, {3'd3, 11'h344});
        wait_idle();
        bus_wr(2'b00, 8'h27);
        bus_wr(2'b01, 8'h80);
        check("mode", {effect, csm}, 2'b11);
        wait_idle();
        // Slot 3 is not a channel: window but no strobe
        bus_wr(2'b00, 8'h33);
        bus_wr(2'b01, 8'h5A);
        check("inv_busy", {busy, up_keyon, up_alg, up_fnumlo, up_pms, up_dt1, up_tl, up_ks_ar,
              up_amen_dr, up_sr, up_sl_rr, up_ssgeg}, 12'h800);
        wait_idle();
        // Back-to-back data writes, address change while pending, third write dropped
        bus_wr(2'b00, 8'h40);
        busy_cycles = 0;
        bus_wr(2'b01, 8'h11);
        bus_wr(2'b01, 8'h22);
        bus_wr(2'b00, 8'h4C);
        bus_wr(2'b01, 8'h33);
        wait_idle();
        check("b2b_len", busy_cycles, QUEUE ? 48 : 24);
        check("b2b_dout", {dout, ch, op}, {QUEUE ? 8'h22 : 8'h11, 3'd0, 2'd0});
        // Reset at tick 10 of a window
        bus_wr(2'b00, 8'h4A);
        bus_wr(2'b01, 8'h55);
        repeat (9) @(negedge clk);
        check("pre_rst", {busy, up_tl}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {busy, up_tl, dout, ch, op, latch_fnum, effect, csm}, '0);
        check("rst_ch3", {fnum_ch3op1, block_ch3op1}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_wr(2'b00, 8'h4A);
        bus_wr(2'b01, 8'h5A);
        check("post_rst", {up_tl, busy, ch, dout}, {1'b1, 1'b1, 3'd2, 8'h5A});
        wait_idle();
        // Random traffic with gated clk_en
        en_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 19);
            rv = k < 16 ? tbl[k] : 8'($urandom);
            p = 1'($urandom);
            if ($urandom_range(0, 2) != 0) bus_wr({p, 1'b0}, rv);
            bus_wr({p, 1'b1}, 8'($urandom));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
